// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the sdram_controller request bus among NP requesters.
// In-order read tags route responses back. Define SDRAM_ARB_PORT0_PRIO_EN for port-0 priority.
module sdram_port_arbiter #(
   parameter int unsigned NP   = 4,
   parameter int unsigned AW   = 24,
   parameter int unsigned DW   = 16,
   parameter int unsigned TAGD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NP-1:0]        s_req_valid,
   input  logic [NP-1:0]        s_req_write,
   input  logic [NP*AW-1:0]     s_req_addr,
   input  logic [NP*DW-1:0]     s_req_wdata,
   input  logic [NP*DW/8-1:0]   s_req_byteenable,
   output logic [NP-1:0]        s_req_ready,
   output logic [NP-1:0]        s_rsp_early_valid,
   output logic [NP-1:0]        s_rsp_valid,
   output logic [DW-1:0]        s_rsp_rdata,
   output logic                 m_req_valid,
   output logic                 m_req_write,
   output logic [AW-1:0]        m_req_addr,
   output logic [DW-1:0]        m_req_wdata,
   output logic [DW/8-1:0]      m_req_byteenable,
   input  logic                 m_req_ready,
   input  logic                 m_rsp_early_valid,
   input  logic                 m_rsp_valid,
   input  logic [DW-1:0]        m_rsp_rdata,
   output logic                 err_orphan
);
   localparam int unsigned BW = DW / 8;
   localparam int unsigned TW = (NP > 1) ? $clog2(NP) : 1;
   localparam int unsigned PW = (TAGD > 1) ? $clog2(TAGD) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t        state, state_n;
   logic [TW-1:0] gnt, gnt_n, rr_ptr, rr_ptr_n;
   logic          load;
   logic [NP-1:0] eligible;

   logic [TW-1:0] tag_mem [TAGD];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          tag_full, tag_empty, push, pop;
   logic [TW-1:0] head;

   assign tag_full    = (count == CW'(TAGD));
   assign tag_empty   = (count == '0);
   assign head        = tag_mem[rd_ptr];
   assign eligible    = s_req_valid & ~(~s_req_write & {NP{tag_full}});
   assign pop         = m_rsp_valid & ~tag_empty;
   assign s_rsp_rdata = m_rsp_rdata;

   // Arbitration and handshake: pick a winner in IDLE, present it in ISSUE until accepted
   always_comb begin
      state_n     = state;
      gnt_n       = gnt;
      rr_ptr_n    = rr_ptr;
      load        = 1'b0;
      push        = 1'b0;
      s_req_ready = '0;
      case (state)
         IDLE: begin
`ifdef SDRAM_ARB_PORT0_PRIO_EN
            if (eligible[0]) begin
               load  = 1'b1;
               gnt_n = '0;
            end
            for (int unsigned k = 0; k < NP; k++) begin
               if (!load && (TW'((32'(rr_ptr) + k) % NP) != '0) &&
                   eligible[TW'((32'(rr_ptr) + k) % NP)]) begin
                  load  = 1'b1;
                  gnt_n = TW'((32'(rr_ptr) + k) % NP);
               end
            end
`else
            for (int unsigned k = 0; k < NP; k++) begin
               if (!load && eligible[TW'((32'(rr_ptr) + k) % NP)]) begin
                  load  = 1'b1;
                  gnt_n = TW'((32'(rr_ptr) + k) % NP);
               end
            end
`endif
            if (load) state_n = ISSUE;
         end
         ISSUE: begin
            if (m_req_ready) begin
               s_req_ready[gnt] = 1'b1;
               push             = ~m_req_write;
               state_n          = IDLE;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
               if (gnt != '0)
                  rr_ptr_n = (gnt == TW'(NP - 1)) ? '0 : gnt + 1'b1;
`else
               rr_ptr_n = (gnt == TW'(NP - 1)) ? '0 : gnt + 1'b1;
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State, grant and held request fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         gnt              <= '0;
         rr_ptr           <= '0;
         m_req_valid      <= 1'b0;
         m_req_write      <= 1'b0;
         m_req_addr       <= '0;
         m_req_wdata      <= '0;
         m_req_byteenable <= '0;
         err_orphan       <= 1'b0;
      end else begin
         state       <= state_n;
         gnt         <= gnt_n;
         rr_ptr      <= rr_ptr_n;
         m_req_valid <= (state_n == ISSUE);
         if (load) begin
            m_req_write      <= s_req_write[gnt_n];
            m_req_addr       <= s_req_addr[32'(gnt_n) * AW +: AW];
            m_req_wdata      <= s_req_wdata[32'(gnt_n) * DW +: DW];
            m_req_byteenable <= s_req_byteenable[32'(gnt_n) * BW +: BW];
         end
         if (m_rsp_valid && tag_empty) err_orphan <= 1'b1;
      end
   end

   // Tag FIFO pointers; TAGD is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem[wr_ptr] <= gnt;
   end

   // Response strobes go only to the port at the FIFO head
   always_comb begin
      s_rsp_valid       = '0;
      s_rsp_early_valid = '0;
      for (int unsigned i = 0; i < NP; i++) begin
         s_rsp_valid[i]       = m_rsp_valid & ~tag_empty & (head == TW'(i));
         s_rsp_early_valid[i] = m_rsp_early_valid & ~tag_empty & (head == TW'(i));
      end
   end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: table vectors, directed corner sequences and random traffic
// checked against a queue-based reference model.
module tb_sdram_port_arbiter;
   localparam int unsigned NP = 4, AW = 24, DW = 16, TAGD = 4, BW = 2;
`ifdef SDRAM_ARB_PORT0_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NP-1:0]    p_valid = '0, p_write = '0;
   logic [AW-1:0]    p_addr  [NP];
   logic [DW-1:0]    p_wdata [NP];
   logic [BW-1:0]    p_be    [NP];
   logic [NP*AW-1:0] s_req_addr;
   logic [NP*DW-1:0] s_req_wdata;
   logic [NP*BW-1:0] s_req_byteenable;
   logic [NP-1:0]    s_req_ready, s_rsp_early_valid, s_rsp_valid;
   logic [DW-1:0]    s_rsp_rdata;
   logic             m_req_valid, m_req_write;
   logic [AW-1:0]    m_req_addr;
   logic [DW-1:0]    m_req_wdata;
   logic [BW-1:0]    m_req_byteenable;
   logic             m_req_ready = 1'b0, m_rsp_early_valid = 1'b0, m_rsp_valid = 1'b0;
   logic [DW-1:0]    m_rsp_rdata = '0;
   logic             err_orphan;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NP; i++) begin
         s_req_addr[i*AW +: AW]       = p_addr[i];
         s_req_wdata[i*DW +: DW]      = p_wdata[i];
         s_req_byteenable[i*BW +: BW] = p_be[i];
      end
   end

   sdram_port_arbiter #(.NP(NP), .AW(AW), .DW(DW), .TAGD(TAGD)) dut (
      .clk(clk), .rst(rst),
      .s_req_valid(p_valid), .s_req_write(p_write), .s_req_addr(s_req_addr),
      .s_req_wdata(s_req_wdata), .s_req_byteenable(s_req_byteenable),
      .s_req_ready(s_req_ready), .s_rsp_early_valid(s_rsp_early_valid),
      .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata),
      .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
      .m_req_wdata(m_req_wdata), .m_req_byteenable(m_req_byteenable),
      .m_req_ready(m_req_ready), .m_rsp_early_valid(m_rsp_early_valid),
      .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .err_orphan(err_orphan)
   );

   // Reference model: pending grant, rotating pointer, queue of issuing ports
   bit            busy;
   int            gnt, ptr;
   int            q[$];
   bit            orphan;
   logic          f_write;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_wdata;
   logic [BW-1:0] f_be;
   logic [NP-1:0] acc, dut_ready;
   int            n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NP-1:0] elig);
      if (PRIO && elig[0]) return 0;
      for (int k = 0; k < NP; k++) begin
         int idx;
         idx = (ptr + k) % NP;
         if (PRIO && idx == 0) continue;
         if (elig[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      busy = 0; gnt = 0; ptr = 0; orphan = 0;
      q.delete();
   endtask

   // Check the current cycle against the model, then advance model and clock
   task automatic step();
      logic [NP-1:0] e_ready, e_rsp, e_early, elig;
      int qs, w;
      #1;
      e_ready = (busy && m_req_ready) ? (4'b0001 << gnt) : 4'b0000;
      e_rsp   = 4'b0000;
      e_early = 4'b0000;
      if (q.size() > 0) begin
         if (m_rsp_valid)       e_rsp   = 4'b0001 << q[0];
         if (m_rsp_early_valid) e_early = 4'b0001 << q[0];
      end
      chk("m_req_valid", 32'(m_req_valid), 32'(busy));
      if (busy) begin
         chk("m_req_write", 32'(m_req_write), 32'(f_write));
         chk("m_req_addr", 32'(m_req_addr), 32'(f_addr));
         chk("m_req_wdata", 32'(m_req_wdata), 32'(f_wdata));
         chk("m_req_byteenable", 32'(m_req_byteenable), 32'(f_be));
      end
      chk("s_req_ready", 32'(s_req_ready), 32'(e_ready));
      chk("s_rsp_valid", 32'(s_rsp_valid), 32'(e_rsp));
      chk("s_rsp_early_valid", 32'(s_rsp_early_valid), 32'(e_early));
      chk("s_rsp_rdata", 32'(s_rsp_rdata), 32'(m_rsp_rdata));
      chk("err_orphan", 32'(err_orphan), 32'(orphan));
      acc       = e_ready;
      dut_ready = s_req_ready;
      qs = q.size();
      if (m_rsp_valid) begin
         if (qs > 0) void'(q.pop_front());
         else orphan = 1;
      end
      if (busy) begin
         if (m_req_ready) begin
            if (!f_write) q.push_back(gnt);
            if (!(PRIO && gnt == 0)) ptr = (gnt + 1) % NP;
            busy = 0;
         end
      end else begin
         elig = p_valid & ~(~p_write & {NP{qs >= TAGD}});
         w = pick(elig);
         if (w >= 0) begin
            busy = 1; gnt = w;
            f_write = p_write[w]; f_addr = p_addr[w]; f_wdata = p_wdata[w]; f_be = p_be[w];
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p_valid = '0; p_write = '0;
      m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_early_valid = 1'b0; m_rsp_rdata = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic new_req(input int i);
      p_valid[i] = 1'b1;
      p_write[i] = 1'($urandom_range(1, 0));
      p_addr[i]  = 24'($urandom);
      p_wdata[i] = 16'($urandom);
      p_be[i]    = 2'($urandom);
   endtask

   typedef struct {
      logic [3:0]  valid, write;
      logic        mrdy, rspv;
      logic [15:0] rdata;
      logic [3:0]  e_ready, e_rsp;
      logic        e_mv, e_err;
   } vec_t;
   vec_t tbl [17];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int c0, c1, c2;
      for (int i = 0; i < NP; i++) begin
         p_addr[i]  = 24'h000100 + 24'(i);
         p_wdata[i] = 16'h1000 + 16'(i);
         p_be[i]    = 2'(i);
      end
      // valid, write, mrdy, rspv, rdata, exp ready, exp rsp, exp m_req_valid, exp err
      tbl[0]  = '{4'hF, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[1]  = '{4'hF, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h1, 4'h0, 1'b1, 1'b0};
      tbl[2]  = '{4'hE, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[3]  = '{4'hE, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h2, 4'h0, 1'b1, 1'b0};
      tbl[4]  = '{4'hC, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[5]  = '{4'hC, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h4, 4'h0, 1'b1, 1'b0};
      tbl[6]  = '{4'h8, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[7]  = '{4'h8, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h8, 4'h0, 1'b1, 1'b0};
      tbl[8]  = '{4'h0, 4'h0, 1'b1, 1'b1, 16'hA5A5, 4'h0, 4'h1, 1'b0, 1'b0};
      tbl[9]  = '{4'h0, 4'h0, 1'b1, 1'b1, 16'h5A5A, 4'h0, 4'h2, 1'b0, 1'b0};
      tbl[10] = '{4'h0, 4'h0, 1'b1, 1'b1, 16'h1234, 4'h0, 4'h4, 1'b0, 1'b0};
      tbl[11] = '{4'h0, 4'h0, 1'b1, 1'b1, 16'hFFFF, 4'h0, 4'h8, 1'b0, 1'b0};
      tbl[12] = '{4'h0, 4'h0, 1'b1, 1'b1, 16'hBEEF, 4'h0, 4'h0, 1'b0, 1'b0};
      tbl[13] = '{4'h0, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1};
      tbl[14] = '{4'h1, 4'h0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b1};
      tbl[15] = '{4'h1, 4'h0, 1'b0, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b1};
      tbl[16] = '{4'h1, 4'h0, 1'b1, 1'b0, 16'h0000, 4'h1, 4'h0, 1'b1, 1'b1};

      do_reset();
      for (int r = 0; r < 17; r++) begin
         p_valid = tbl[r].valid; p_write = tbl[r].write;
         m_req_ready = tbl[r].mrdy;
         m_rsp_valid = tbl[r].rspv; m_rsp_early_valid = tbl[r].rspv;
         m_rsp_rdata = tbl[r].rdata;
         #1;
         chk($sformatf("row%0d ready", r), 32'(s_req_ready), 32'(tbl[r].e_ready));
         chk($sformatf("row%0d rsp", r), 32'(s_rsp_valid), 32'(tbl[r].e_rsp));
         chk($sformatf("row%0d early", r), 32'(s_rsp_early_valid), 32'(tbl[r].e_rsp));
         chk($sformatf("row%0d m_valid", r), 32'(m_req_valid), 32'(tbl[r].e_mv));
         chk($sformatf("row%0d err", r), 32'(err_orphan), 32'(tbl[r].e_err));
         step();
      end

      // Port 2 fills the tag FIFO; its fifth read stalls while a port 1 write still issues
      do_reset();
      p_valid = 4'b0100; m_req_ready = 1'b1;
      c1 = 0; c2 = 0;
      for (int k = 0; k < 12; k++) begin step(); c2 += int'(dut_ready[2]); end
      chk("full: port2 reads accepted", 32'(c2), 32'd4);
      p_valid = 4'b0110; p_write = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         step();
         c1 += int'(dut_ready[1]);
         c2 += int'(dut_ready[2]);
         if (acc[1]) p_valid[1] = 1'b0;
      end
      chk("full: port1 write accepted", 32'(c1), 32'd1);
      chk("full: port2 still stalled", 32'(c2), 32'd4);

      // Reads from port 3 then port 1; two beats route back in order
      do_reset();
      m_req_ready = 1'b1;
      p_valid = 4'b1000; step(); step(); p_valid = 4'b0000;
      p_valid = 4'b0010; step(); step(); p_valid = 4'b0000;
      m_rsp_valid = 1'b1; m_rsp_rdata = 16'hA5A5;
      #1 chk("route beat0 port3", 32'(s_rsp_valid), 32'h8);
      step();
      m_rsp_rdata = 16'h5A5A;
      #1 chk("route beat1 port1", 32'(s_rsp_valid), 32'h2);
      chk("route beat1 data", 32'(s_rsp_rdata), 32'h5A5A);
      step();
      m_rsp_valid = 1'b0;
      step();

      // Reset while a grant is pending clears grant, tags and pointer
      do_reset();
      p_valid = 4'b0001; m_req_ready = 1'b1;
      step(); step();
      p_valid = 4'b0100; m_req_ready = 1'b0;
      step();
      chk("pre-reset m_req_valid", 32'(m_req_valid), 32'd1);
      rst = 1'b1;
      #1 chk("reset m_req_valid", 32'(m_req_valid), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      p_valid = 4'b1111; p_write = 4'b0000; m_req_ready = 1'b1; m_rsp_valid = 1'b1;
      #1 chk("reset fifo empty no strobe", 32'(s_rsp_valid), 32'h0);
      step();
      m_rsp_valid = 1'b0;
      step();
      chk("reset pointer port0 first", 32'(dut_ready), 32'h1);
      chk("orphan after reset", 32'(err_orphan), 32'd1);

`ifdef SDRAM_ARB_PORT0_PRIO_EN
      // Port 0 priority over a continuously requesting port 1
      do_reset();
      p_valid = 4'b0011; p_write = 4'b0011; m_req_ready = 1'b1;
      c0 = 0; c1 = 0;
      for (int k = 0; k < 8; k++) begin
         step(); c0 += int'(dut_ready[0]); c1 += int'(dut_ready[1]);
      end
      chk("prio port0 grants", 32'(c0), 32'd4);
      chk("prio port1 starved", 32'(c1), 32'd0);
      p_valid[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin step(); c1 += int'(dut_ready[1]); end
      chk("prio port1 after drop", 32'(c1), 32'd2);
`else
      c0 = 0;
`endif

      // Random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NP; i++)
            if (!p_valid[i] && $urandom_range(2, 0) == 0) new_req(i);
         m_req_ready       = ($urandom_range(2, 0) != 0);
         m_rsp_valid       = (q.size() > 0) && ($urandom_range(2, 0) == 0);
         m_rsp_early_valid = (q.size() > 0) && ($urandom_range(1, 0) == 0);
         m_rsp_rdata       = 16'($urandom);
         step();
         p_valid = p_valid & ~acc;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
